// File: rtl/trg_out_ctrl_pkg.sv
// Shared types and constants for the trigger output controller.
package trg_out_ctrl_pkg;

    // Encoding of the idle state; the other states follow it.
    localparam logic [1:0] IDLE = 2'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_PULSE = IDLE + 2'd1,
        ST_DEAD  = IDLE + 2'd2
    } trgState_t;

    // One check trigger every 4096 effective triggers.
    localparam logic [11:0] CHK_PERIOD_MASK = 12'hFFF;

    localparam int PULSE_CNT_W = 8;
    localparam int DEAD_CNT_W  = 16;

    // True when the count of already-issued triggers lands on a check slot.
    // A count of zero (including wrap) never selects the check width.
    function automatic logic isCheckCount(input logic [15:0] cnt);
        return ((cnt[11:0] & CHK_PERIOD_MASK) == 12'd0) && (cnt != 16'd0);
    endfunction

endpackage

// File: rtl/trg_out_ctrl_edge_det.sv
// Registers one trigger source and flags its rising edge.
module trg_edge_det (
    input  logic clk_in,
    input  logic rst_in,
    input  logic sig_in,
    output logic rise_out
);

    logic r_cur;
    logic r_prev;

    // Keep the current and previous sampled level of the source.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_cur  <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_cur  <= sig_in;
            r_prev <= r_cur;
        end
    end

    assign rise_out = r_cur & ~r_prev;

endmodule

// File: rtl/trg_out_ctrl.sv
// Trigger output controller: merges three trigger sources into one
// effective trigger, drives the active-low front-end pulse and a DAQ busy
// flag that spans the pulse plus a programmable dead time.
// Define CHK_TRG_EN to stretch every 4096th pulse to the check width.
module trg_out_ctrl
    import trg_out_ctrl_pkg::*;
#(
    parameter int TRG_PULSE_WIDTH = 20,
    parameter int CHK_PULSE_WIDTH = 50,
    parameter int DEAD_UNIT       = 50
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        coincid_trg_in,
    input  logic        ext_trg_syn_in,
    input  logic        cycled_trg_in,
    input  logic        trg_enb_in,
    input  logic [7:0]  trg_dead_time_in,
    input  logic [15:0] eff_trg_cnt_in,
    output logic        eff_trg_out,
    output logic        trg_out_N,
    output logic        daq_busy_out
);

    localparam logic [PULSE_CNT_W-1:0] W_TRG   = PULSE_CNT_W'(TRG_PULSE_WIDTH);
    localparam logic [PULSE_CNT_W-1:0] W_CHK   = PULSE_CNT_W'(CHK_PULSE_WIDTH);
    localparam logic [DEAD_CNT_W-1:0]  W_UNIT  = DEAD_CNT_W'(DEAD_UNIT);
    localparam logic [PULSE_CNT_W-1:0] P_ONE   = PULSE_CNT_W'(1);
    localparam logic [DEAD_CNT_W-1:0]  D_ONE   = DEAD_CNT_W'(1);

    logic                   w_riseCoinc;
    logic                   w_riseExt;
    logic                   w_riseCycled;
    logic                   w_trigReq;
    logic [PULSE_CNT_W-1:0] w_width;
    trgState_t              r_state;
    trgState_t              w_nextState;
    logic                   w_start;
    logic                   w_loadDead;
    logic [PULSE_CNT_W-1:0] r_pulseCnt;
    logic [DEAD_CNT_W-1:0]  r_deadCnt;
    logic                   r_start;
    logic                   r_effOut;
    logic                   r_trgOutN;
    logic                   r_busyOut;

    trg_edge_det u_edgeCoinc (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .sig_in   (coincid_trg_in),
        .rise_out (w_riseCoinc)
    );

    trg_edge_det u_edgeExt (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .sig_in   (ext_trg_syn_in),
        .rise_out (w_riseExt)
    );

    trg_edge_det u_edgeCycled (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .sig_in   (cycled_trg_in),
        .rise_out (w_riseCycled)
    );

    assign w_trigReq = (w_riseCoinc | w_riseExt | w_riseCycled) & trg_enb_in;

`ifdef CHK_TRG_EN
    assign w_width = isCheckCount(eff_trg_cnt_in) ? W_CHK : W_TRG;
`else
    logic w_unusedCnt;
    assign w_unusedCnt = ^eff_trg_cnt_in;
    assign w_width     = W_TRG;
`endif

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state plus counter-load strobes; requests outside idle are dropped.
    always_comb begin
        w_nextState = r_state;
        w_start     = 1'b0;
        w_loadDead  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_trigReq) begin
                    w_nextState = ST_PULSE;
                    w_start     = 1'b1;
                end
            end
            ST_PULSE: begin
                if (r_pulseCnt == P_ONE) begin
                    if (trg_dead_time_in == 8'd0) begin
                        w_nextState = ST_IDLE;
                    end else begin
                        w_nextState = ST_DEAD;
                        w_loadDead  = 1'b1;
                    end
                end
            end
            ST_DEAD: begin
                if (r_deadCnt == D_ONE) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Pulse and dead-time down-counters, loaded on entry to their state.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_pulseCnt <= '0;
            r_deadCnt  <= '0;
        end else begin
            if (w_start) begin
                r_pulseCnt <= w_width;
            end else if (r_state == ST_PULSE && r_pulseCnt != '0) begin
                r_pulseCnt <= r_pulseCnt - P_ONE;
            end
            if (w_loadDead) begin
                r_deadCnt <= DEAD_CNT_W'(trg_dead_time_in) * W_UNIT;
            end else if (r_state == ST_DEAD && r_deadCnt != '0) begin
                r_deadCnt <= r_deadCnt - D_ONE;
            end
        end
    end

    // Registered outputs, one cycle behind the state so all three align.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_start   <= 1'b0;
            r_effOut  <= 1'b0;
            r_trgOutN <= 1'b1;
            r_busyOut <= 1'b0;
        end else begin
            r_start   <= w_start;
            r_effOut  <= r_start;
            r_trgOutN <= (r_state != ST_PULSE);
            r_busyOut <= (r_state != ST_IDLE);
        end
    end

    assign eff_trg_out  = r_effOut;
    assign trg_out_N    = r_trgOutN;
    assign daq_busy_out = r_busyOut;

endmodule

// File: tb/tb_trg_out_ctrl.sv
// Testbench for trg_out_ctrl: a timeline model of each trigger is checked
// against the outputs on every falling clock edge, and directed scenarios
// pin pulse widths, busy lengths and latency to hand-computed numbers.
module tb_trg_out_ctrl;

    localparam int TRG_W  = 20;
    localparam int UNIT   = 50;
`ifdef CHK_TRG_EN
    localparam int CHK_EXP = 50;
`else
    localparam int CHK_EXP = 20;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        coincid_trg_in = 1'b0;
    logic        ext_trg_syn_in = 1'b0;
    logic        cycled_trg_in = 1'b0;
    logic        trg_enb_in = 1'b0;
    logic [7:0]  trg_dead_time_in = 8'd0;
    logic [15:0] eff_trg_cnt_in = 16'd0;
    logic        eff_trg_out;
    logic        trg_out_N;
    logic        daq_busy_out;

    int checks = 0;
    int errors = 0;

    trg_out_ctrl dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .coincid_trg_in   (coincid_trg_in),
        .ext_trg_syn_in   (ext_trg_syn_in),
        .cycled_trg_in    (cycled_trg_in),
        .trg_enb_in       (trg_enb_in),
        .trg_dead_time_in (trg_dead_time_in),
        .eff_trg_cnt_in   (eff_trg_cnt_in),
        .eff_trg_out      (eff_trg_out),
        .trg_out_N        (trg_out_N),
        .daq_busy_out     (daq_busy_out)
    );

    // 50 MHz clock.
    always #10 clk_in = ~clk_in;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Pulse width the board must use for a given already-issued count.
    function automatic int modelWidth(input int cnt);
`ifdef CHK_TRG_EN
        if (cnt % 4096 == 0 && cnt != 0) return 50;
`endif
        return TRG_W;
    endfunction

    // Timeline model: each accepted trigger is an edge number plus durations.
    int          edgeNum = 0;
    logic [2:0]  s1 = 3'b000;
    logic [2:0]  s2 = 3'b000;
    logic [2:0]  rise;
    bit          active = 0;
    bit          idle;
    int          start = 0;
    int          width = 0;
    int          endEdge = 0;
    int          expEff = 0;
    int          expTrgN = 1;
    int          expBusy = 0;

    // Advance the model one clock edge, or clear it on reset.
    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            edgeNum = 0; s1 = 3'b000; s2 = 3'b000; active = 0;
            start = 0; width = 0; endEdge = 0;
            expEff = 0; expTrgN = 1; expBusy = 0;
        end else begin
            edgeNum++;
            rise = s1 & ~s2;
            s2 = s1;
            s1 = {cycled_trg_in, ext_trg_syn_in, coincid_trg_in};
            if (active && edgeNum == start + width)
                endEdge = start + width + int'(trg_dead_time_in) * UNIT;
            idle = !active || (edgeNum >= endEdge + 1);
            if (idle && rise != 3'b000 && trg_enb_in) begin
                active  = 1;
                start   = edgeNum;
                width   = modelWidth(int'(eff_trg_cnt_in));
                endEdge = start + width + 1000000;
            end
            expEff  = (active && edgeNum == start + 1) ? 1 : 0;
            expTrgN = (active && edgeNum >= start + 1 && edgeNum <= start + width) ? 0 : 1;
            expBusy = (active && edgeNum >= start + 1 && edgeNum <= endEdge) ? 1 : 0;
        end
    end

    // Compare the DUT against the model every cycle.
    always @(negedge clk_in) begin
        checkOutput("eff_trg_out", int'(eff_trg_out), expEff);
        checkOutput("trg_out_N", int'(trg_out_N), expTrgN);
        checkOutput("daq_busy_out", int'(daq_busy_out), expBusy);
    end

    // Drive sources per mask {cycled, ext, coincid}, optionally drop them after
    // hold cycles and add a late coincidence pulse, and tally output activity.
    task automatic applyStimulus(input logic [2:0] mask, input int hold, input int lateAt,
                                 input int win, output int lowCnt, output int busyCnt,
                                 output int effCnt, output int firstEff);
        lowCnt = 0; busyCnt = 0; effCnt = 0; firstEff = -1;
        if (mask[0]) coincid_trg_in = 1'b1;
        if (mask[1]) ext_trg_syn_in = 1'b1;
        if (mask[2]) cycled_trg_in  = 1'b1;
        for (int i = 0; i < win; i++) begin
            @(negedge clk_in);
            if (eff_trg_out) begin
                effCnt++;
                if (firstEff < 0) firstEff = i;
            end
            if (!trg_out_N) lowCnt++;
            if (daq_busy_out) busyCnt++;
            if (hold > 0 && i == hold - 1) begin
                if (mask[0]) coincid_trg_in = 1'b0;
                if (mask[1]) ext_trg_syn_in = 1'b0;
                if (mask[2]) cycled_trg_in  = 1'b0;
            end
            if (lateAt > 0 && i == lateAt)     coincid_trg_in = 1'b1;
            if (lateAt > 0 && i == lateAt + 3) coincid_trg_in = 1'b0;
        end
    endtask

    // Hard stop in case anything stalls.
    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    int lowCnt, busyCnt, effCnt, firstEff;
    int cntVals [4] = '{4096, 4095, 4097, 0};
    int cntExp  [4] = '{CHK_EXP, 20, 20, 20};

    // Directed scenarios.
    initial begin
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        checkOutput("reset_eff", int'(eff_trg_out), 0);
        checkOutput("reset_trgN", int'(trg_out_N), 1);
        checkOutput("reset_busy", int'(daq_busy_out), 0);

        $display("[TB] disabled trigger");
        trg_enb_in = 1'b0;
        applyStimulus(3'b001, 8, 0, 12, lowCnt, busyCnt, effCnt, firstEff);
        checkOutput("disabled_eff", effCnt, 0);
        checkOutput("disabled_busy", busyCnt, 0);

        $display("[TB] basic trigger dead=2");
        trg_enb_in = 1'b1;
        eff_trg_cnt_in = 16'd1;
        trg_dead_time_in = 8'd2;
        applyStimulus(3'b001, 8, 0, 140, lowCnt, busyCnt, effCnt, firstEff);
        checkOutput("basic_latency", firstEff, 2);
        checkOutput("basic_eff", effCnt, 1);
        checkOutput("basic_low", lowCnt, 20);
        checkOutput("basic_busy", busyCnt, 120);

        $display("[TB] check-width selection");
        trg_dead_time_in = 8'd0;
        for (int k = 0; k < 4; k++) begin
            eff_trg_cnt_in = 16'(cntVals[k]);
            applyStimulus(3'b001, 3, 0, 70, lowCnt, busyCnt, effCnt, firstEff);
            checkOutput("width_low", lowCnt, cntExp[k]);
            checkOutput("width_busy", busyCnt, cntExp[k]);
        end

        $display("[TB] merged edges and dropped request");
        eff_trg_cnt_in = 16'd5;
        trg_dead_time_in = 8'd1;
        applyStimulus(3'b110, 5, 30, 100, lowCnt, busyCnt, effCnt, firstEff);
        checkOutput("merge_eff", effCnt, 1);
        checkOutput("merge_low", lowCnt, 20);
        checkOutput("merge_busy", busyCnt, 70);

        $display("[TB] held level");
        trg_dead_time_in = 8'd0;
        applyStimulus(3'b100, 0, 0, 100, lowCnt, busyCnt, effCnt, firstEff);
        checkOutput("held_eff", effCnt, 1);
        checkOutput("held_low", lowCnt, 20);
        checkOutput("held_busy", busyCnt, 20);
        cycled_trg_in = 1'b0;
        repeat (3) @(negedge clk_in);

        $display("[TB] reset mid-pulse");
        coincid_trg_in = 1'b1;
        repeat (6) @(negedge clk_in);
        checkOutput("midpulse_low", int'(trg_out_N), 0);
        #2 rst_in = 1'b1;
        #1;
        checkOutput("rst_async_eff", int'(eff_trg_out), 0);
        checkOutput("rst_async_trgN", int'(trg_out_N), 1);
        checkOutput("rst_async_busy", int'(daq_busy_out), 0);
        coincid_trg_in = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        applyStimulus(3'b000, 0, 0, 30, lowCnt, busyCnt, effCnt, firstEff);
        checkOutput("post_rst_eff", effCnt, 0);
        checkOutput("post_rst_low", lowCnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
